// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and pulse-encode active-low push-buttons with optional auto-repeat
//
// Ports:
//   clk_50m     - system clock (50 MHz)
//   rst         - synchronous active-high reset
//   key_in      - raw active-low, asynchronous, bouncing button levels
//   key_pulse_n - one-cycle low pulse per accepted press or auto-repeat, idles high
//   key_level_n - debounced level, low while a key is considered held
module key_debounce #(
    parameter int                N_KEYS        = 4,
    parameter int                DEB_CYCLES    = 1_000_000,
    parameter int                REPEAT_DELAY  = 25_000_000,
    parameter int                REPEAT_PERIOD = 5_000_000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK   = 4'b0100
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_pulse_n,
    output logic [N_KEYS-1:0] key_level_n
);
    localparam int MAXP = (DEB_CYCLES > REPEAT_DELAY)
                        ? ((DEB_CYCLES > REPEAT_PERIOD) ? DEB_CYCLES : REPEAT_PERIOD)
                        : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int CW = (MAXP > 1) ? $clog2(MAXP) : 1;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    logic [N_KEYS-1:0] key_m, key_s;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            key_m <= '1;
            key_s <= '1;
        end else begin
            key_m <= key_in;
            key_s <= key_m;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t        state, state_nxt;
        logic [CW-1:0] deb_cnt, deb_nxt, rep_cnt, rep_nxt;
        logic          first_rep, first_nxt;
        logic          pulse_q, pulse_nxt, level_q, level_nxt;
        logic          deb_done, rep_hit;

        assign deb_done = deb_cnt == CW'(DEB_CYCLES - 1);
        // The first repeat waits the long delay; later ones use the short period.
        assign rep_hit  = rep_cnt == (first_rep ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1));

        always_ff @(posedge clk_50m) begin
            if (rst) begin
                state     <= IDLE;
                deb_cnt   <= '0;
                rep_cnt   <= '0;
                first_rep <= 1'b0;
                pulse_q   <= 1'b1;
                level_q   <= 1'b1;
            end else begin
                state     <= state_nxt;
                deb_cnt   <= deb_nxt;
                rep_cnt   <= rep_nxt;
                first_rep <= first_nxt;
                pulse_q   <= pulse_nxt;
                level_q   <= level_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            deb_nxt   = deb_cnt;
            rep_nxt   = rep_cnt;
            first_nxt = first_rep;
            case (state)
                IDLE: begin
                    if (!key_s[i]) begin
                        state_nxt = PRESS_DB;
                        deb_nxt   = CW'(1);
                    end
                end
                PRESS_DB: begin
                    if (key_s[i]) begin
                        state_nxt = IDLE;
                    end else if (deb_done) begin
                        state_nxt = HELD;
                        rep_nxt   = '0;
                        first_nxt = 1'b0;
                    end else begin
                        deb_nxt = deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_s[i]) begin
                        state_nxt = REL_DB;
                        deb_nxt   = CW'(1);
                    end else if (REPEAT_MASK[i]) begin
                        rep_nxt   = rep_hit ? '0 : rep_cnt + 1'b1;
                        first_nxt = first_rep | rep_hit;
                    end
                end
                REL_DB: begin
                    // A bounce back to pressed restarts the repeat schedule from scratch.
                    if (!key_s[i]) begin
                        state_nxt = HELD;
                        rep_nxt   = '0;
                        first_nxt = 1'b0;
                    end else if (deb_done) begin
                        state_nxt = IDLE;
                    end else begin
                        deb_nxt = deb_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_comb begin
            pulse_nxt = !((state == PRESS_DB && !key_s[i] && deb_done) ||
                          (state == HELD && !key_s[i] && REPEAT_MASK[i] && rep_hit));
            level_nxt = (state_nxt == IDLE) || (state_nxt == PRESS_DB);
        end

        assign key_pulse_n[i] = pulse_q;
        assign key_level_n[i] = level_q;
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomized check of key_debounce against a behavioural model
module tb_key_debounce;
    localparam int DEB    = 8;
    localparam int DELAY  = 40;
    localparam int PERIOD = 10;
    localparam logic [3:0] MASK = 4'b0100;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] key_in  = 4'hF;
    logic [3:0] key_pulse_n, key_level_n;

    key_debounce #(
        .N_KEYS(4), .DEB_CYCLES(DEB), .REPEAT_DELAY(DELAY),
        .REPEAT_PERIOD(PERIOD), .REPEAT_MASK(MASK)
    ) dut (
        .clk_50m(clk_50m), .rst(rst), .key_in(key_in),
        .key_pulse_n(key_pulse_n), .key_level_n(key_level_n)
    );

    always #5 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Behavioural model: a key is accepted after DEB consecutive synchronised samples
    // disagreeing with the accepted level; while held, repeats fall at ages
    // DELAY, DELAY+PERIOD, ... counted from the press or from a release bounce-back.
    logic [3:0] ms1 = 4'hF, ms2 = 4'hF, acc = 4'h0;
    logic [3:0] exp_pulse = 4'hF, exp_level = 4'hF;
    int run [4] = '{0, 0, 0, 0};
    int age [4] = '{0, 0, 0, 0};

    int pcnt [4]  = '{0, 0, 0, 0};
    int plast [4] = '{-1, -1, -1, -1};
    int lfall [4] = '{-1, -1, -1, -1};
    int lrise [4] = '{-1, -1, -1, -1};
    logic [3:0] lvl_prev = 4'hF;
    int n0110 = 0, nother = 0;

    initial begin
        @(posedge clk_50m);
        forever begin
            @(negedge clk_50m);
            chk("model_pulse", 32'(key_pulse_n), 32'(exp_pulse));
            chk("model_level", 32'(key_level_n), 32'(exp_level));
            for (int i = 0; i < 4; i++) begin
                if (key_pulse_n[i] === 1'b0) begin
                    pcnt[i]++;
                    plast[i] = cyc;
                end
                if (key_level_n[i] === 1'b0 && lvl_prev[i]) lfall[i] = cyc;
                if (key_level_n[i] === 1'b1 && !lvl_prev[i]) lrise[i] = cyc;
            end
            lvl_prev = key_level_n;
            if (key_pulse_n === 4'b0110) n0110++;
            else if (key_pulse_n !== 4'hF) nother++;
            if (rst) begin
                ms1 = 4'hF; ms2 = 4'hF; acc = 4'h0;
                exp_pulse = 4'hF; exp_level = 4'hF;
                for (int i = 0; i < 4; i++) begin
                    run[i] = 0;
                    age[i] = 0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    exp_pulse[i] = 1'b1;
                    if (!acc[i]) begin
                        run[i] = ms2[i] ? 0 : run[i] + 1;
                        if (run[i] == DEB) begin
                            acc[i] = 1'b1; run[i] = 0; age[i] = 0; exp_pulse[i] = 1'b0;
                        end
                    end else if (ms2[i]) begin
                        run[i]++;
                        if (run[i] == DEB) begin
                            acc[i] = 1'b0; run[i] = 0;
                        end
                    end else if (run[i] != 0) begin
                        run[i] = 0; age[i] = 0;
                    end else begin
                        age[i]++;
                        if (MASK[i] && age[i] >= DELAY && (age[i] - DELAY) % PERIOD == 0)
                            exp_pulse[i] = 1'b0;
                    end
                    exp_level[i] = !acc[i];
                end
                ms2 = ms1;
                ms1 = key_in;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50m);
        #2;
    endtask

    int t, c0, c1, c2, a, b;

    initial begin
        tick(3);
        rst = 1'b0;
        tick(5);
        chk("reset_pulse", 32'(key_pulse_n), 32'hF);
        chk("reset_level", 32'(key_level_n), 32'hF);

        c0 = pcnt[0]; t = cyc; key_in[0] = 1'b0; tick(30);
        chk("clean_count", pcnt[0] - c0, 1);
        chk("clean_time", plast[0], t + 10);
        chk("clean_level", lfall[0], t + 10);
        chk("clean_others", pcnt[1] + pcnt[2] + pcnt[3], 0);

        key_in[0] = 1'b1; tick(3);
        key_in[0] = 1'b0; tick(5);
        key_in[0] = 1'b1; t = cyc; tick(20);
        chk("relbounce_count", pcnt[0] - c0, 1);
        chk("relbounce_level", lrise[0], t + 10);

        c1 = pcnt[1]; key_in[1] = 1'b0; tick(5);
        key_in[1] = 1'b1; tick(2);
        key_in[1] = 1'b0; t = cyc; tick(30);
        chk("pressbounce_count", pcnt[1] - c1, 1);
        chk("pressbounce_time", plast[1], t + 10);
        key_in[1] = 1'b1; tick(20);

        c0 = pcnt[0]; c2 = pcnt[2];
        key_in[0] = 1'b0; key_in[2] = 1'b0; t = cyc; tick(100);
        key_in[0] = 1'b1; key_in[2] = 1'b1; tick(20);
        chk("repeat_count", pcnt[2] - c2, 7);
        chk("repeat_last", plast[2], t + 100);
        chk("norepeat_count", pcnt[0] - c0, 1);
        chk("norepeat_time", plast[0], t + 10);

        a = n0110; b = nother;
        key_in = 4'b0110; t = cyc; tick(20);
        key_in = 4'hF; tick(20);
        chk("simul_count", n0110 - a, 1);
        chk("simul_other", nother - b, 0);
        chk("simul_time", plast[3], t + 10);

        c0 = pcnt[0]; key_in[0] = 1'b0; t = cyc; tick(5);
        rst = 1'b1; tick(1);
        chk("midrst_pulse", 32'(key_pulse_n), 32'hF);
        chk("midrst_level", 32'(key_level_n), 32'hF);
        rst = 1'b0; tick(30);
        chk("midrst_count", pcnt[0] - c0, 1);
        chk("midrst_time", plast[0], t + 16);
        key_in[0] = 1'b1; tick(20);

        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) key_in[i] = ~key_in[i];
            rst = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
